// File: rtl/ecc_param_loader_if.sv
// Host word stream and assembled-operand bundle between the host and ecc_param_loader.
// The host drives the i_* signals through the master modport; the loader uses the slave modport.
interface ecc_param_loader_if #(
  parameter int MAX_BITS = 256,
  parameter int WORD_W   = 32
);
  logic                i_clear;
  logic                i_valid;
  logic [WORD_W-1:0]   i_data;
  logic                o_ready;
  logic [MAX_BITS-1:0] o_Px;
  logic [MAX_BITS-1:0] o_Py;
  logic [MAX_BITS-1:0] o_prime;
  logic [MAX_BITS-1:0] o_a;
  logic [MAX_BITS-1:0] o_b;
  logic [MAX_BITS-1:0] o_m;
  logic [MAX_BITS-1:0] o_nPx;
  logic [MAX_BITS-1:0] o_nPy;
  logic                o_m_P_valid;
  logic                o_nP_valid;
  logic                o_err;

  modport master (
    output i_clear, i_valid, i_data,
    input  o_ready, o_Px, o_Py, o_prime, o_a, o_b, o_m, o_nPx, o_nPy,
    input  o_m_P_valid, o_nP_valid, o_err
  );

  modport slave (
    input  i_clear, i_valid, i_data,
    output o_ready, o_Px, o_Py, o_prime, o_a, o_b, o_m, o_nPx, o_nPy,
    output o_m_P_valid, o_nP_valid, o_err
  );
endinterface

// File: rtl/ecc_param_loader.sv
// Assembles MSW-first host words into the ECC core operands (phase 1: Px,Py,prime,a,b,m; phase 2: nPx,nPy).
// Define ECC_LOADER_RANGE_CHECK_EN to add one-cycle range-check states before each valid is raised.
module ecc_param_loader #(
  parameter int MAX_BITS = 256,
  parameter int WORD_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  ecc_param_loader_if.slave  bus
);

  localparam int NW  = MAX_BITS / WORD_W;
  localparam int WCW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [WCW-1:0] WLAST = WCW'(NW - 1);

  typedef enum logic [2:0] {
    LOAD_P  = 3'd0,
    LOAD_NP = 3'd1,
    NP_DONE = 3'd2,
    ERR     = 3'd3,
    CHK_P   = 3'd4,
    CHK_NP  = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [WCW-1:0]      r_word;
  logic [2:0]          r_field;
  logic [MAX_BITS-1:0] r_op [8];

  logic w_ready_st;
  logic w_mpv;
  logic w_npv;
  logic w_err;
  logic w_ready;
  logic w_beat;
  logic w_last_p;
  logic w_last_np;

  // o_ready is forced low while reset is asserted and rises as soon as it is released.
  assign w_ready   = w_ready_st & rst;
  assign w_beat    = bus.i_valid & w_ready & ~bus.i_clear;
  assign w_last_p  = (r_field == 3'd5) && (r_word == WLAST);
  assign w_last_np = (r_field == 3'd7) && (r_word == WLAST);

`ifdef ECC_LOADER_RANGE_CHECK_EN
  logic w_p_ok;
  logic w_np_ok;

  function automatic logic below(input logic [MAX_BITS-1:0] v, input logic [MAX_BITS-1:0] lim);
    return v < lim;
  endfunction

  assign w_p_ok  = below(r_op[0], r_op[2]) && below(r_op[1], r_op[2]) &&
                   below(r_op[3], r_op[2]) && below(r_op[4], r_op[2]) && (r_op[5] != '0);
  assign w_np_ok = below(r_op[6], r_op[2]) && below(r_op[7], r_op[2]);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= LOAD_P;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (bus.i_clear) begin
      w_next = LOAD_P;
    end else begin
      case (r_state)
`ifdef ECC_LOADER_RANGE_CHECK_EN
        LOAD_P:  if (w_beat && w_last_p)  w_next = CHK_P;
        LOAD_NP: if (w_beat && w_last_np) w_next = CHK_NP;
        CHK_P:   w_next = w_p_ok  ? LOAD_NP : ERR;
        CHK_NP:  w_next = w_np_ok ? NP_DONE : ERR;
`else
        LOAD_P:  if (w_beat && w_last_p)  w_next = LOAD_NP;
        LOAD_NP: if (w_beat && w_last_np) w_next = NP_DONE;
`endif
        default: w_next = r_state;
      endcase
    end
  end

  // Entering LOAD_NP is the phase-1 done point: m_P_valid rises with no bubble before phase 2.
  always_comb begin
    w_ready_st = (r_state == LOAD_P) || (r_state == LOAD_NP);
    w_mpv      = (r_state == LOAD_NP) || (r_state == CHK_NP) || (r_state == NP_DONE);
    w_npv      = (r_state == NP_DONE);
    w_err      = (r_state == ERR);
  end

  // Field index runs 0..7 across both phases, so phase-2 fields land in r_op[6], r_op[7].
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_word  <= '0;
      r_field <= '0;
    end else if (bus.i_clear) begin
      r_word  <= '0;
      r_field <= '0;
    end else if (w_beat) begin
      if (r_word == WLAST) begin
        r_word  <= '0;
        r_field <= r_field + 3'd1;
      end else begin
        r_word  <= r_word + WCW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 8; k++) r_op[k] <= '0;
    end else if (w_beat) begin
      r_op[r_field] <= (r_op[r_field] << WORD_W) | MAX_BITS'(bus.i_data);
    end
  end

  assign bus.o_ready     = w_ready;
  assign bus.o_Px        = r_op[0];
  assign bus.o_Py        = r_op[1];
  assign bus.o_prime     = r_op[2];
  assign bus.o_a         = r_op[3];
  assign bus.o_b         = r_op[4];
  assign bus.o_m         = r_op[5];
  assign bus.o_nPx       = r_op[6];
  assign bus.o_nPy       = r_op[7];
  assign bus.o_m_P_valid = w_mpv;
  assign bus.o_nP_valid  = w_npv;
`ifdef ECC_LOADER_RANGE_CHECK_EN
  assign bus.o_err       = w_err;
`else
  assign bus.o_err       = 1'b0;
`endif

endmodule
